// File: rtl/vscale_htif_host_poller.sv
// Host-side HTIF PCR master: periodically polls to_host, streams nonzero
// values to the host, latches a sticky exit code on the first odd value,
// and converts host writes into from_host PCR writes.
module vscale_htif_host_poller #(
  parameter int unsigned       POLL_INTERVAL  = 64,
  parameter int unsigned       ADDR_W         = 12,
  parameter int unsigned       PCR_W          = 64,
  parameter int unsigned       XLEN           = 32,
  parameter logic [ADDR_W-1:0] TO_HOST_ADDR   = 12'h780,
  parameter logic [ADDR_W-1:0] FROM_HOST_ADDR = 12'h781
) (
  input  logic              clk,
  input  logic              reset,
  output logic              pcr_req_valid_o,
  input  logic              pcr_req_ready_i,
  output logic              pcr_req_rw_o,
  output logic [ADDR_W-1:0] pcr_req_addr_o,
  output logic [PCR_W-1:0]  pcr_req_data_o,
  input  logic              pcr_resp_valid_i,
  output logic              pcr_resp_ready_o,
  input  logic [PCR_W-1:0]  pcr_resp_data_i,
  output logic              tohost_valid_o,
  input  logic              tohost_ready_i,
  output logic [XLEN-1:0]   tohost_data_o,
  input  logic              fromhost_valid_i,
  output logic              fromhost_ready_o,
  input  logic [XLEN-1:0]   fromhost_data_i,
  output logic              exit_valid_o,
  output logic [XLEN-2:0]   exit_code_o
);

  localparam int unsigned CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    PUSH,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  tohost_data_q, tohost_data_d;
  logic             exit_valid_q, exit_valid_d;
  logic [XLEN-2:0]  exit_code_q, exit_code_d;

  logic             req_valid_c;
  logic             resp_ready_c;
  logic             tohost_valid_c;
  logic             fromhost_ready_c;
  logic [XLEN-1:0]  resp_v;
  logic             unused_resp_upper;

  assign resp_v            = pcr_resp_data_i[XLEN-1:0];
  assign unused_resp_upper = ^pcr_resp_data_i[PCR_W-1:XLEN];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      poll_cnt_q    <= CNT_RELOAD;
      wdata_q       <= '0;
      tohost_data_q <= '0;
      exit_valid_q  <= 1'b0;
      exit_code_q   <= '0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      wdata_q       <= wdata_d;
      tohost_data_q <= tohost_data_d;
      exit_valid_q  <= exit_valid_d;
      exit_code_q   <= exit_code_d;
    end
  end

  // Next-state and handshake decode; a single PCR transaction at a time.
  always_comb begin
    state_d          = state_q;
    poll_cnt_d       = poll_cnt_q;
    wdata_d          = wdata_q;
    tohost_data_d    = tohost_data_q;
    exit_valid_d     = exit_valid_q;
    exit_code_d      = exit_code_q;
    req_valid_c      = 1'b0;
    resp_ready_c     = 1'b0;
    tohost_valid_c   = 1'b0;
    fromhost_ready_c = 1'b0;
    pcr_req_rw_o     = 1'b0;
    pcr_req_addr_o   = TO_HOST_ADDR;
    pcr_req_data_o   = '0;

    case (state_q)
      IDLE: begin
        fromhost_ready_c = 1'b1;
        if (poll_cnt_q != '0) begin
          poll_cnt_d = poll_cnt_q - 1'b1;
        end
        if (fromhost_valid_i) begin
          wdata_d = fromhost_data_i;
          state_d = WR_REQ;
        end else if ((poll_cnt_q == '0) && !exit_valid_q) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        req_valid_c = 1'b1;
        if (pcr_req_ready_i) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        resp_ready_c = 1'b1;
        if (pcr_resp_valid_i) begin
          if (resp_v == '0) begin
            state_d    = IDLE;
            poll_cnt_d = CNT_RELOAD;
          end else begin
            tohost_data_d = resp_v;
            state_d       = PUSH;
            if (resp_v[0] && !exit_valid_q) begin
              exit_valid_d = 1'b1;
              exit_code_d  = resp_v[XLEN-1:1];
            end
          end
        end
      end
      PUSH: begin
        tohost_valid_c = 1'b1;
        if (tohost_ready_i) begin
          state_d    = IDLE;
          poll_cnt_d = CNT_RELOAD;
        end
      end
      WR_REQ: begin
        req_valid_c    = 1'b1;
        pcr_req_rw_o   = 1'b1;
        pcr_req_addr_o = FROM_HOST_ADDR;
        pcr_req_data_o = {{(PCR_W-XLEN){1'b0}}, wdata_q};
        if (pcr_req_ready_i) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        resp_ready_c = 1'b1;
        if (pcr_resp_valid_i) begin
          state_d = IDLE;
          // A poll that was already due when the write won stays due.
          if (poll_cnt_q != '0) begin
            poll_cnt_d = CNT_RELOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are held low while reset is asserted.
  assign pcr_req_valid_o  = req_valid_c & ~reset;
  assign pcr_resp_ready_o = resp_ready_c & ~reset;
  assign tohost_valid_o   = tohost_valid_c & ~reset;
  assign fromhost_ready_o = fromhost_ready_c & ~reset;
  assign tohost_data_o    = tohost_data_q;
  assign exit_valid_o     = exit_valid_q;
  assign exit_code_o      = exit_code_q;

endmodule

// File: tb/tb_vscale_htif_host_poller.sv
// Directed bench for vscale_htif_host_poller with a small HTIF core model
// and scoreboards for PCR requests and to_host pushes.
module tb_vscale_htif_host_poller;

  localparam int unsigned POLL = 4;

  typedef struct packed {
    logic        rw;
    logic [11:0] addr;
    logic [63:0] data;
  } reqExp_t;

  logic        clk;
  logic        reset;
  logic        pcrReqValid;
  logic        pcrReqReady;
  logic        pcrReqRw;
  logic [11:0] pcrReqAddr;
  logic [63:0] pcrReqData;
  logic        pcrRespValid;
  logic        pcrRespReady;
  logic [63:0] pcrRespData;
  logic        tohostValid;
  logic        tohostReady;
  logic [31:0] tohostData;
  logic        fromhostValid;
  logic        fromhostReady;
  logic [31:0] fromhostData;
  logic        exitValid;
  logic [30:0] exitCode;

  reqExp_t     expReq[$];
  logic [31:0] expPush[$];
  logic [31:0] toHostModel;
  logic [31:0] fromHostModel;
  int          compared;
  int          mismatched;
  int          n;

  vscale_htif_host_poller #(
    .POLL_INTERVAL(POLL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pcr_req_valid_o (pcrReqValid),
    .pcr_req_ready_i (pcrReqReady),
    .pcr_req_rw_o    (pcrReqRw),
    .pcr_req_addr_o  (pcrReqAddr),
    .pcr_req_data_o  (pcrReqData),
    .pcr_resp_valid_i(pcrRespValid),
    .pcr_resp_ready_o(pcrRespReady),
    .pcr_resp_data_i (pcrRespData),
    .tohost_valid_o  (tohostValid),
    .tohost_ready_i  (tohostReady),
    .tohost_data_o   (tohostData),
    .fromhost_valid_i(fromhostValid),
    .fromhost_ready_o(fromhostReady),
    .fromhost_data_i (fromhostData),
    .exit_valid_o    (exitValid),
    .exit_code_o     (exitCode)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: score handshakes seen before the edge, then let the
  // core model react to them after the edge.
  task automatic applyStimulus();
    logic    fReq, fResp, fPush, fHost, rwSnap;
    logic [63:0] dataSnap;
    reqExp_t e;
    logic [31:0] p;
    #1;
    fReq     = pcrReqValid && pcrReqReady;
    fResp    = pcrRespValid && pcrRespReady;
    fPush    = tohostValid && tohostReady;
    fHost    = fromhostValid && fromhostReady;
    rwSnap   = pcrReqRw;
    dataSnap = pcrReqData;
    if (fReq) begin
      checkOutput("req_was_expected", 64'(expReq.size() != 0), 64'd1);
      if (expReq.size() != 0) begin
        e = expReq.pop_front();
        checkOutput("req_rw", 64'(pcrReqRw), 64'(e.rw));
        checkOutput("req_addr", 64'(pcrReqAddr), 64'(e.addr));
        checkOutput("req_data", pcrReqData, e.data);
      end
    end
    if (fPush) begin
      checkOutput("push_was_expected", 64'(expPush.size() != 0), 64'd1);
      if (expPush.size() != 0) begin
        p = expPush.pop_front();
        checkOutput("push_data", 64'(tohostData), 64'(p));
      end
    end
    @(posedge clk);
    #1;
    if (fReq) begin
      pcrRespValid = 1'b1;
      if (rwSnap) begin
        fromHostModel = dataSnap[31:0];
        pcrRespData   = 64'h1234_5678_9ABC_DEF0;
      end else begin
        pcrRespData = {32'hCAFE_F00D, toHostModel};
        toHostModel = 32'h0;
      end
    end else if (fResp) begin
      pcrRespValid = 1'b0;
    end
    if (fHost) begin
      fromhostValid = 1'b0;
    end
    #1;
  endtask

  // Cycles from now until the next rising edge of the request valid.
  task automatic waitReqRise(input int maxCycles, output int cnt);
    cnt = 0;
    #1;
    while (pcrReqValid && cnt < maxCycles) begin
      applyStimulus();
      cnt++;
    end
    while (!pcrReqValid && cnt < maxCycles) begin
      applyStimulus();
      cnt++;
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b1;
    pcrReqReady   = 1'b1;
    pcrRespValid  = 1'b0;
    pcrRespData   = 64'h0;
    tohostReady   = 1'b1;
    fromhostValid = 1'b0;
    fromhostData  = 32'h0;
    toHostModel   = 32'h0;
    fromHostModel = 32'h0;

    // Reset values.
    repeat (3) applyStimulus();
    checkOutput("rst_req_valid", 64'(pcrReqValid), 64'd0);
    checkOutput("rst_resp_ready", 64'(pcrRespReady), 64'd0);
    checkOutput("rst_tohost_valid", 64'(tohostValid), 64'd0);
    checkOutput("rst_fromhost_ready", 64'(fromhostReady), 64'd0);
    checkOutput("rst_req_rw", 64'(pcrReqRw), 64'd0);
    checkOutput("rst_req_addr", 64'(pcrReqAddr), 64'h780);
    checkOutput("rst_req_data", pcrReqData, 64'd0);
    checkOutput("rst_tohost_data", 64'(tohostData), 64'd0);
    checkOutput("rst_exit_valid", 64'(exitValid), 64'd0);
    checkOutput("rst_exit_code", 64'(exitCode), 64'd0);
    reset = 1'b0;

    // Idle polling of a zero to_host.
    $display("[TB] zero to_host polling");
    repeat (3) expReq.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
    waitReqRise(50, n);
    checkOutput("first_poll_delay", 64'(n), 64'(POLL));
    waitReqRise(50, n);
    checkOutput("poll_period_1", 64'(n), 64'(POLL + 2));
    waitReqRise(50, n);
    checkOutput("poll_period_2", 64'(n), 64'(POLL + 2));
    checkOutput("zero_exit_valid", 64'(exitValid), 64'd0);

    // Nonzero even value with host backpressure.
    $display("[TB] to_host 0x10 with backpressure");
    toHostModel = 32'h10;
    expPush.push_back(32'h10);
    tohostReady = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("push_valid", 64'(tohostValid), 64'd1);
    checkOutput("push_data_0x10", 64'(tohostData), 64'h10);
    checkOutput("push_exit_valid", 64'(exitValid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("stall_tohost_valid", 64'(tohostValid), 64'd1);
      checkOutput("stall_tohost_data", 64'(tohostData), 64'h10);
      checkOutput("stall_req_valid", 64'(pcrReqValid), 64'd0);
    end
    tohostReady = 1'b1;
    expReq.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
    applyStimulus();
    waitReqRise(50, n);
    checkOutput("resume_poll_delay", 64'(n), 64'(POLL));

    // Odd value latches the exit and stops polling.
    $display("[TB] to_host 0x3 exit");
    toHostModel = 32'h3;
    expPush.push_back(32'h3);
    applyStimulus();
    applyStimulus();
    checkOutput("exit_push_valid", 64'(tohostValid), 64'd1);
    checkOutput("exit_push_data", 64'(tohostData), 64'h3);
    checkOutput("exit_valid", 64'(exitValid), 64'd1);
    checkOutput("exit_code", 64'(exitCode), 64'd1);
    applyStimulus();
    toHostModel = 32'h5;
    repeat (20) applyStimulus();
    checkOutput("post_exit_req_valid", 64'(pcrReqValid), 64'd0);
    checkOutput("post_exit_tohost_valid", 64'(tohostValid), 64'd0);
    checkOutput("post_exit_sticky", 64'(exitValid), 64'd1);
    checkOutput("post_exit_code", 64'(exitCode), 64'd1);
    checkOutput("to_host_5_unread", 64'(toHostModel), 64'h5);

    // Host write wins over a poll that is due in the same cycle.
    $display("[TB] host write priority");
    reset       = 1'b1;
    toHostModel = 32'h0;
    applyStimulus();
    reset = 1'b0;
    checkOutput("rst2_exit_valid", 64'(exitValid), 64'd0);
    checkOutput("rst2_exit_code", 64'(exitCode), 64'd0);
    checkOutput("rst2_tohost_data", 64'(tohostData), 64'd0);
    repeat (POLL - 1) applyStimulus();
    fromhostValid = 1'b1;
    fromhostData  = 32'hDEAD_BEEF;
    expReq.push_back('{rw: 1'b1, addr: 12'h781, data: 64'h0000_0000_DEAD_BEEF});
    expReq.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
    applyStimulus();
    checkOutput("wr_req_valid", 64'(pcrReqValid), 64'd1);
    checkOutput("wr_req_rw", 64'(pcrReqRw), 64'd1);
    checkOutput("wr_req_addr", 64'(pcrReqAddr), 64'h781);
    checkOutput("wr_req_data", pcrReqData, 64'h0000_0000_DEAD_BEEF);
    applyStimulus();
    applyStimulus();
    checkOutput("after_wr_req_valid", 64'(pcrReqValid), 64'd0);
    checkOutput("after_wr_idle", 64'(fromhostReady), 64'd1);
    checkOutput("from_host_written", 64'(fromHostModel), 64'hDEAD_BEEF);
    applyStimulus();
    checkOutput("due_poll_valid", 64'(pcrReqValid), 64'd1);
    checkOutput("due_poll_rw", 64'(pcrReqRw), 64'd0);
    checkOutput("due_poll_addr", 64'(pcrReqAddr), 64'h780);

    // Request stalled by the core, then reset mid-transaction.
    $display("[TB] request stall and reset in RD_RESP");
    pcrReqReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
      checkOutput("stall_req_valid_hold", 64'(pcrReqValid), 64'd1);
      checkOutput("stall_req_addr_hold", 64'(pcrReqAddr), 64'h780);
      checkOutput("stall_req_rw_hold", 64'(pcrReqRw), 64'd0);
    end
    pcrReqReady = 1'b1;
    applyStimulus();
    checkOutput("rd_resp_ready", 64'(pcrRespReady), 64'd1);
    reset = 1'b1;
    applyStimulus();
    reset        = 1'b0;
    pcrRespValid = 1'b0;
    #1;
    checkOutput("midrst_req_valid", 64'(pcrReqValid), 64'd0);
    checkOutput("midrst_resp_ready", 64'(pcrRespReady), 64'd0);
    checkOutput("midrst_tohost_valid", 64'(tohostValid), 64'd0);
    checkOutput("midrst_idle", 64'(fromhostReady), 64'd1);
    expReq.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
    waitReqRise(50, n);
    checkOutput("midrst_poll_delay", 64'(n), 64'(POLL));
    applyStimulus();
    applyStimulus();
    checkOutput("req_queue_drained", 64'(expReq.size()), 64'd0);
    checkOutput("push_queue_drained", 64'(expPush.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
